aes256_rev_key_stream: RTL and testbench
========================================

// Module: aes256_rev_key_stream
// PURPOSE
//  AES-256 decryption-side round-key source. Takes a cipher key and runs the schedule forward to
//  the end, then plays the 15 round keys back in reverse order (rk14 first, rk0 last).
//  Playback uses a valid/ready stream consumed by the inverse-cipher datapath.
//  Sits beside the forward key_expansion block. It serves decryption, the other direction of the same schedule.
//  Optionally accepts {rk13,rk14} directly so the forward walk can be skipped.
// PARAMETERS
//  NK      8   key words (fixed to 8 for AES-256; any other value is a synthesis error)
//  NR      14  number of rounds; last round-key index
// PORTS
//  clk          in   1    clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  start        in   1    begin a run; sampled only in IDLE
//  key_is_last  in   1    sampled with start: 1 = key_in is {rk13,rk14}; 0 = key_in is the cipher key
//  key_in       in   256  key material, word0 = [255:224]
//  busy         out  1    high from the start-sampling edge until done
//  rk_valid     out  1    rk_o/rk_idx are valid
//  rk_ready     in   1    consumer accepts the current round key
//  rk_o         out  128  round key, w[4r] in [127:96]
//  rk_idx       out  4    round index r of rk_o (14 down to 0)
//  done         out  1    one-cycle pulse on the cycle after rk0 is accepted
// BEHAVIOUR
//  - Reset: state=IDLE; window W[0..7], step counter and rk_idx cleared; busy, rk_valid, done = 0; rk_o = 0.
//  - Window: W holds 8 words {rk(r-1), rk(r)}; rk_o = W[4..7], except rk_idx==0, where rk_o = W[0..3].
//  - States: IDLE -> FWD -> STREAM -> IDLE.
//    IDLE: on start, load W <= key_in.
//      key_is_last=0: go FWD with s=2.
//      key_is_last=1: go STREAM with rk_idx=14.
//    FWD: one forward step per clock; W <= {W[4..7], new4}; s++.
//      After the step producing rk14 (13 steps), go STREAM with rk_idx=14.
//    STREAM: rk_valid=1. On rk_valid & rk_ready:
//      rk_idx>=2: backward step, W <= {old4, W[0..3]}; rk_idx--.
//      rk_idx==1: no step; rk_idx <= 0.
//      rk_idx==0: go IDLE; done=1 for one cycle; busy and rk_valid drop.
//  - Latency: rk_valid rises 14 clocks after the start-sampling edge (1 clock if key_is_last=1).
//    Keys then stream one per clock while rk_ready=1.
//  - Stall: while rk_valid & ~rk_ready, rk_o and rk_idx hold stable.
//  - Forward step, producing rk s, word k=4s:
//    w[k]   = w[k-8] ^ T(w[k-1]), where
//      T = SubWord(RotWord(x)) ^ {Rcon[s/2-1],24'h0} when s is even;
//      T = SubWord(x) when s is odd.
//    w[k+j] = w[k+j-8] ^ w[k+j-1] for j=1..3 (ripple within the step).
//  - Backward step, window {rk(r-1),rk(r)} yields rk(r-2); all terms come from the current window, no ripple:
//    w[4r-8+j] = w[4r+j] ^ w[4r+j-1] for j=1..3;
//    w[4r-8]   = w[4r] ^ T(w[4r-1]), where
//      T = SubWord(RotWord(x)) ^ {Rcon[r/2-1],24'h0} when r is even;
//      T = SubWord(x) when r is odd.
//  - Sharing: one shared 4-byte forward S-box bank is used by FWD and STREAM (never both in one cycle).
//  - start while busy is ignored; key_in and key_is_last are don't-care outside IDLE.
//  - Async reset mid-run aborts immediately: all state and outputs return to reset values, and no done is issued.
// STRUCTURE
//  - Shared package aes_pkg: Rcon table (8'h01..8'h40, 7 entries); AES256_NR=14; AES256_NK=8; state encoding.
//  - Sub-module: reuse SubBytes_mix x4 with ZF=1 (forward S-box) as the shared SubWord bank.
//  - Everything else is inline: FSM, window registers, step/index counters, and the two XOR networks.
// TESTING
//  1. FIPS-197 key 00010203..1e1f, key_is_last=0, rk_ready=1 -> rk_valid at +14 clocks. Then:
//     rk14=24fc79ccbf0979e9371ac23c6d68de36 (idx 14), continuing to rk2=a573c29fa176c498a97fce93a572c09c,
//     rk1=101112131415161718191a1b1c1d1e1f, rk0=000102030405060708090a0b0c0d0e0f;
//     done pulses the following cycle.
//  2. Same key, key_is_last=1 with {rk13,rk14} captured in test 1 -> valid after 1 clock; identical 15-key sequence.
//  3. Random rk_ready backpressure (including 5-cycle stalls at idx 14, 1 and 0) -> rk_o and rk_idx are stable
//     during stalls; the sequence matches the golden C model; exactly 15 handshakes.
//  4. start pulsed during FWD and during STREAM with a different key_in -> ignored; output matches the first key.
//  5. rst_n asserted at FWD step 7 and again at STREAM idx 9 -> all outputs read 0 and done never pulses.
//     A new start then completes normally.
//  6. 1000 random keys vs the golden model, both key_is_last modes, back-to-back runs (start on the cycle after done).

Source files
------------

// File: rtl/aes256_rev_key_stream_pkg.sv
// Shared AES-256 key-schedule constants, FSM state type and GF(2^8) helpers
// used by the reverse round-key stream.
package aes256_rev_key_stream_pkg;

    localparam int unsigned AES256_NK = 8;
    localparam int unsigned AES256_NR = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_STREAM
    } state_t;

    // Rcon[i] for i = 0..6 (8'h01..8'h40)
    function automatic logic [7:0] rcon_of(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h01;
            3'd1:    return 8'h02;
            3'd2:    return 8'h04;
            3'd3:    return 8'h08;
            3'd4:    return 8'h10;
            3'd5:    return 8'h20;
            3'd6:    return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes256_rev_key_stream_if.sv
// Control and round-key stream signals of the reverse key stream block.
interface aes256_rev_key_stream_if;

    logic         start;
    logic         key_is_last;
    logic [255:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_o;
    logic [3:0]   rk_idx;
    logic         done;

    modport master (
        output start, key_is_last, key_in, rk_ready,
        input  busy, rk_valid, rk_o, rk_idx, done
    );

    modport slave (
        input  start, key_is_last, key_in, rk_ready,
        output busy, rk_valid, rk_o, rk_idx, done
    );

endinterface

// File: rtl/aes256_rev_key_stream_sbox.sv
// Forward AES S-box for one byte: GF(2^8) inverse followed by the affine map.
module aes256_rev_key_stream_sbox
    import aes256_rev_key_stream_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes256_rev_key_stream.sv
// AES-256 decryption round-key source: walks the schedule forward to rk14,
// then streams rk14..rk0 over a valid/ready handshake by stepping backward.
module aes256_rev_key_stream
    import aes256_rev_key_stream_pkg::*;
#(
    parameter int unsigned NK = AES256_NK,
    parameter int unsigned NR = AES256_NR
) (
    input  logic                          clk,
    input  logic                          rst_n,
    aes256_rev_key_stream_if.slave        ks
);

    if (NK != AES256_NK) begin : g_nk_check
        $error("aes256_rev_key_stream supports NK=8 only");
    end

    state_t      state;
    state_t      state_nxt;
    logic [31:0] w [8];
    logic [3:0]  step;
    logic [3:0]  rk_idx_q;
    logic        done_q;

    logic        fwd;
    logic [31:0] sb_in;
    logic [31:0] sb_out;
    logic [3:0]  rnd;
    logic [31:0] t_word;
    logic [31:0] f_new [4];
    logic [31:0] b_new [4];

    // One S-box bank serves both directions: FWD transforms W[7], STREAM W[3]
    always_comb begin
        fwd   = (state == ST_FWD);
        sb_in = fwd ? w[7] : w[3];
        rnd   = fwd ? step : rk_idx_q;
    end

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes256_rev_key_stream_sbox u_sbox (
            .a (sb_in[8*g +: 8]),
            .y (sb_out[8*g +: 8])
        );
    end

    // SubWord commutes with RotWord, so rotating after substitution is equivalent
    always_comb begin
        if (rnd[0]) begin
            t_word = sb_out;
        end else begin
            t_word = {sb_out[23:0], sb_out[31:24]} ^ {rcon_of(rnd[3:1] - 3'd1), 24'h0};
        end
        f_new[0] = w[0] ^ t_word;
        for (int unsigned j = 1; j < 4; j++) begin
            f_new[j] = w[j] ^ f_new[j-1];
        end
        b_new[0] = w[4] ^ t_word;
        for (int unsigned j = 1; j < 4; j++) begin
            b_new[j] = w[4+j] ^ w[3+j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (ks.start) state_nxt = ks.key_is_last ? ST_STREAM : ST_FWD;
            ST_FWD:    if (step == 4'(NR)) state_nxt = ST_STREAM;
            ST_STREAM: if (ks.rk_ready && rk_idx_q == '0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 8; k++) w[k] <= '0;
            step     <= '0;
            rk_idx_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (ks.start) begin
                        for (int unsigned k = 0; k < 8; k++) w[k] <= ks.key_in[255-32*k -: 32];
                        step     <= 4'd2;
                        rk_idx_q <= 4'(NR);
                    end
                end
                ST_FWD: begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        w[k]   <= w[k+4];
                        w[k+4] <= f_new[k];
                    end
                    step <= step + 4'd1;
                end
                ST_STREAM: begin
                    if (ks.rk_ready) begin
                        if (rk_idx_q >= 4'd2) begin
                            for (int unsigned k = 0; k < 4; k++) begin
                                w[k]   <= b_new[k];
                                w[k+4] <= w[k];
                            end
                            rk_idx_q <= rk_idx_q - 4'd1;
                        end else if (rk_idx_q == 4'd1) begin
                            rk_idx_q <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ks.busy     = (state != ST_IDLE);
        ks.rk_valid = (state == ST_STREAM);
        ks.done     = done_q;
        ks.rk_idx   = rk_idx_q;
        ks.rk_o     = (rk_idx_q == '0) ? {w[0], w[1], w[2], w[3]} : {w[4], w[5], w[6], w[7]};
    end

endmodule

// File: tb/tb_aes256_rev_key_stream.sv
// Self-checking bench for aes256_rev_key_stream against a table-based FIPS-197 schedule model.
module tb_aes256_rev_key_stream;

    logic clk;
    logic rst_n;
    aes256_rev_key_stream_if bus ();

    aes256_rev_key_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [31:0]  mw     [0:59];
    logic [127:0] exp_rk [0:14];
    logic [127:0] cap    [0:14];

    typedef struct {
        int           idx;
        logic [127:0] rk;
    } golden_t;
    golden_t golden [4];

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        logic [2047:0] t;
        logic [31:0]   r;
        t = SBOX_TBL;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = t[2047 - 8*int'(x[8*b +: 8]) -: 8];
        end
        return r;
    endfunction

    // Standard FIPS-197 KeyExpansion for Nk=8, then group words into round keys
    task automatic model_expand(input logic [255:0] key);
        logic [7:0]  rc;
        logic [31:0] tmp;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) mw[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = mw[i-1];
            if (i % 8 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            mw[i] = mw[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endtask

    // Called at a negedge; returns at the negedge where done is expected high.
    // mode 0: rk_ready always 1; mode 1: random with 5-cycle stalls at idx 14, 1, 0.
    task automatic run(input logic [255:0] key, input bit is_last, input int mode, input bit inject);
        int   lat;
        int   got;
        int   cyc;
        int   stall;
        int   forced_at;
        bit   prev_stall;
        logic [127:0] held_rk;
        logic [3:0]   held_idx;
        bus.rk_ready    = 1'b0;
        bus.start       = 1'b1;
        bus.key_in      = key;
        bus.key_is_last = is_last;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        chk("busy_after_start", 256'(bus.busy), 256'(1));
        chk("done_clear", 256'(bus.done), 256'(0));
        while (!bus.rk_valid && lat < 40) begin
            bus.start  = inject && lat == 5;
            bus.key_in = ~key;
            bus.key_is_last = 1'b1;
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk("latency", 256'(lat), 256'(is_last ? 1 : 14));

        got = 0; cyc = 0; stall = 0; forced_at = -1; prev_stall = 1'b0;
        held_rk = '0; held_idx = '0;
        while (got < 15 && cyc < 3000) begin
            chk("rk_valid", 256'(bus.rk_valid), 256'(1));
            chk("done_low", 256'(bus.done), 256'(0));
            if (prev_stall) begin
                chk("stall_rk_o", 256'(bus.rk_o), 256'(held_rk));
                chk("stall_rk_idx", 256'(bus.rk_idx), 256'(held_idx));
            end
            chk("rk_idx", 256'(bus.rk_idx), 256'(14 - got));
            chk("rk_o", 256'(bus.rk_o), 256'(exp_rk[14 - got]));
            cap[14 - got] = bus.rk_o;
            if (mode == 1 && forced_at != got && (got == 0 || got == 13 || got == 14)) begin
                stall = 5;
                forced_at = got;
            end
            if (stall > 0) begin
                bus.rk_ready = 1'b0;
                stall--;
            end else begin
                bus.rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            prev_stall = !bus.rk_ready;
            held_rk    = bus.rk_o;
            held_idx   = bus.rk_idx;
            if (bus.rk_ready) got++;
            bus.start  = inject && cyc == 3;
            bus.key_in = ~key;
            @(negedge clk);
            cyc++;
        end
        bus.start    = 1'b0;
        bus.rk_ready = 1'b0;
        chk("handshakes", 256'(got), 256'(15));
        chk("done_pulse", 256'(bus.done), 256'(1));
        chk("busy_end", 256'(bus.busy), 256'(0));
        chk("rk_valid_end", 256'(bus.rk_valid), 256'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, 256'({bus.busy, bus.rk_valid, bus.done, bus.rk_idx, bus.rk_o}), 256'(0));
    endtask

    initial begin
        logic [255:0] key;
        bit           saw;
        int           n;

        golden[0] = '{14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        golden[1] = '{2,  128'ha573c29fa176c498a97fce93a572c09c};
        golden[2] = '{1,  128'h101112131415161718191a1b1c1d1e1f};
        golden[3] = '{0,  128'h000102030405060708090a0b0c0d0e0f};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.key_is_last = 1'b0; bus.key_in = '0; bus.rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outs");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: FIPS-197 key, forward walk
        model_expand(FIPS_KEY);
        run(FIPS_KEY, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fips_rk%0d", golden[i].idx), 256'(cap[golden[i].idx]), 256'(golden[i].rk));
        end

        // 2: {rk13,rk14} shortcut
        key = {cap[13], cap[14]};
        run(key, 1'b1, 0, 1'b0);

        // 3: backpressure, both modes
        run(FIPS_KEY, 1'b0, 1, 1'b0);
        run(key, 1'b1, 1, 1'b0);

        // 4: start while busy is ignored
        run(FIPS_KEY, 1'b0, 0, 1'b1);
        run(key, 1'b1, 1, 1'b1);

        // 5a: reset during FWD step 7
        @(negedge clk);
        bus.start = 1'b1; bus.key_in = FIPS_KEY; bus.key_is_last = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_fwd_outs");
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.rk_valid || bus.busy) saw = 1'b1;
        end
        chk("rst_fwd_quiet", 256'(saw), 256'(0));

        // 5b: reset during STREAM at idx 9
        bus.start = 1'b1; bus.key_in = FIPS_KEY; bus.key_is_last = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.rk_ready = 1'b1;
        n = 0;
        while (!(bus.rk_valid && bus.rk_idx == 4'd9) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx9", 256'(n < 100), 256'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_stream_outs");
        bus.rk_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.rk_valid || bus.busy) saw = 1'b1;
        end
        chk("rst_stream_quiet", 256'(saw), 256'(0));
        run(FIPS_KEY, 1'b0, 0, 1'b0);

        // 6: random keys, back-to-back, both modes
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 8; k++) key[32*k +: 32] = $urandom;
            model_expand(key);
            if (i % 2 == 1) run({exp_rk[13], exp_rk[14]}, 1'b1, (i % 4 == 1) ? 1 : 0, 1'b0);
            else            run(key, 1'b0, (i % 4 == 0) ? 1 : 0, 1'b0);
        end

        @(negedge clk);
        chk("done_single_cycle", 256'(bus.done), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
